// File: rtl/sync_fifo_arb_pkg.sv
// Shared state type and sizing helpers for the FIFO write-port arbiter.
package sync_fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  // Source-ID width; kept at one bit minimum so ID ports never collapse.
  function automatic int calc_id_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  // Beat counter must be able to hold MAX_BURST itself.
  function automatic int calc_cnt_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

  localparam int DEFAULT_MAX_BURST = 4;
  localparam int DEFAULT_CNT_W     = $clog2(DEFAULT_MAX_BURST + 1);

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first set request strictly after
// the last pointer, wrapping modulo N.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] cand [N];
  logic [N-1:0]     hit;

  // cand[k] is the requester examined at search offset k+1 from last.
  for (genvar gi = 0; gi < N; gi++) begin : g_cand
    assign cand[gi]  = IDX_W'((int'(last) + gi + 1) % N);
    assign hit[gi]   = req[cand[gi]];
    assign grant[gi] = any & (idx == IDX_W'(gi));
  end

  always_comb begin
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (hit[k]) begin
        idx = cand[k];
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/sync_fifo_wr_arb.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers.
// Define FIFO_WR_ARB_PRIO_EN to make requester 0 win every arbitration it enters.
module sync_fifo_wr_arb
  import sync_fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int MAX_BURST  = 4,
  localparam int ID_W       = calc_id_w(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic [ID_W-1:0]               fifo_wr_id,
  output logic [ID_W-1:0]               grant_id,
  output logic                          busy
);

  localparam int CNT_W = calc_cnt_w(MAX_BURST);

  arb_state_t          state_reg;
  logic [ID_W-1:0]     grant_reg;
  logic [NUM_REQ-1:0]  grant_oh_reg;
  logic [ID_W-1:0]     last_reg;
  logic [CNT_W-1:0]    cnt_reg;

  logic [CNT_W-1:0]    cnt_next;
  logic [ID_W-1:0]     last_next;
  logic [NUM_REQ-1:0]  rr_oh;
  logic [ID_W-1:0]     rr_idx;
  logic                rr_any;
  logic [NUM_REQ-1:0]  pick_oh;
  logic [ID_W-1:0]     pick_idx;
  logic                pick_any;

  logic                in_burst;
  logic                sel_valid;
  logic                sel_last;
  logic                beat;
  logic                burst_done;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [DATA_WIDTH-1:0] masked_data [NUM_REQ];

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_rr_pick (
    .req   (req_valid),
    .last  (last_reg),
    .grant (rr_oh),
    .idx   (rr_idx),
    .any   (rr_any)
  );

`ifdef FIFO_WR_ARB_PRIO_EN
  // Requester 0 jumps the queue but leaves the rotation pointer untouched.
  assign pick_any  = rr_any;
  assign pick_idx  = req_valid[0] ? '0 : rr_idx;
  assign pick_oh   = req_valid[0] ? NUM_REQ'(1) : rr_oh;
  assign last_next = (grant_reg == '0) ? last_reg : grant_reg;
`else
  assign pick_any  = rr_any;
  assign pick_idx  = rr_idx;
  assign pick_oh   = rr_oh;
  assign last_next = grant_reg;
`endif

  assign in_burst  = (state_reg == BURST);
  assign sel_valid = |(req_valid & grant_oh_reg);
  assign sel_last  = |(req_last & grant_oh_reg);
  assign beat      = in_burst & sel_valid & ~fifo_full;
  assign cnt_next  = cnt_reg + CNT_W'(1);

  // An idle requester only loses its grant when the FIFO could have taken data.
  assign burst_done = (beat & (sel_last | (cnt_next == CNT_W'(MAX_BURST))))
                    | (in_burst & ~sel_valid & ~fifo_full);

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mux
    assign masked_data[gi] = grant_oh_reg[gi] ? req_data[gi*DATA_WIDTH +: DATA_WIDTH]
                                              : '0;
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_data = sel_data | masked_data[i];
    end
  end

  assign req_ready    = grant_oh_reg & {NUM_REQ{in_burst & ~fifo_full}};
  assign fifo_wr_en   = beat;
  assign fifo_wr_data = in_burst ? sel_data : '0;
  assign fifo_wr_id   = in_burst ? grant_reg : '0;
  assign grant_id     = grant_reg;
  assign busy         = in_burst;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      grant_oh_reg <= '0;
      cnt_reg      <= '0;
      last_reg     <= ID_W'(NUM_REQ - 1);
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_any) begin
            state_reg    <= BURST;
            grant_reg    <= pick_idx;
            grant_oh_reg <= pick_oh;
            cnt_reg      <= '0;
          end
        end
        BURST: begin
          if (beat) begin
            cnt_reg <= cnt_next;
          end
          if (burst_done) begin
            state_reg <= IDLE;
            last_reg  <= last_next;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sync_fifo_wr_arb.sv
// Directed bench for sync_fifo_wr_arb: queue-driven producers, a per-cycle
// reference model and literal expectations for each scenario.
module tb_sync_fifo_wr_arb;

  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 8;
  localparam int MAX_BURST  = 4;
  localparam int ID_W       = 2;

  logic                          clk = 1'b0;
  logic                          rst_n = 1'b0;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_wr_data;
  logic [ID_W-1:0]               fifo_wr_id;
  logic [ID_W-1:0]               grant_id;
  logic                          busy;

  sync_fifo_wr_arb #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_BURST  (MAX_BURST)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .fifo_wr_id   (fifo_wr_id),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Producer beat queues.
  logic [7:0] pd [NUM_REQ][16];
  logic       pl [NUM_REQ][16];
  int         head [NUM_REQ];
  int         tail [NUM_REQ];

  // Observed FIFO writes.
  int         wcnt = 0;
  int         wid  [64];
  logic [7:0] wdat [64];
  int         wcyc [64];

  // Reference model: owner -1 means no grant held.
  int   m_owner = -1;
  int   m_beats = 0;
  int   m_last  = NUM_REQ - 1;
  int   m_gid   = 0;
  int   m_pick;
  logic m_vld, m_lst, m_beat;

  function automatic int choose(input logic [NUM_REQ-1:0] v, input int last);
    int res;
    res = -1;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (v[(last + k) % NUM_REQ]) res = (last + k) % NUM_REQ;
    end
`ifdef FIFO_WR_ARB_PRIO_EN
    if (v[0]) res = 0;
`endif
    return res;
  endfunction

  always_comb m_pick = choose(req_valid, m_last);

  always_comb begin
    m_vld  = 1'b0;
    m_lst  = 1'b0;
    m_beat = 1'b0;
    if (m_owner >= 0) begin
      m_vld  = req_valid[m_owner];
      m_lst  = req_last[m_owner];
      m_beat = m_vld && !fifo_full;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner <= -1;
      m_beats <= 0;
      m_last  <= NUM_REQ - 1;
      m_gid   <= 0;
    end else if (m_owner < 0) begin
      if (m_pick >= 0) begin
        m_owner <= m_pick;
        m_gid   <= m_pick;
        m_beats <= 0;
      end
    end else begin
      if (m_beat) m_beats <= m_beats + 1;
      if ((m_beat && (m_lst || (m_beats + 1 == MAX_BURST))) || (!m_vld && !fifo_full)) begin
        m_owner <= -1;
`ifdef FIFO_WR_ARB_PRIO_EN
        if (m_owner != 0) m_last <= m_owner;
`else
        m_last <= m_owner;
`endif
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_cycle();
    logic [NUM_REQ-1:0] e_ready;
    int e_id;
    e_ready = '0;
    e_id    = 0;
    if (m_owner >= 0) begin
      e_id = m_owner;
      if (!fifo_full) e_ready[m_owner] = 1'b1;
    end
    chk("busy", busy, m_owner >= 0);
    chk("grant_id", grant_id, m_gid);
    chk("req_ready", req_ready, e_ready);
    chk("fifo_wr_en", fifo_wr_en, m_beat);
    chk("fifo_wr_id", fifo_wr_id, e_id);
    if (m_beat) chk("fifo_wr_data", fifo_wr_data, req_data[m_owner*DATA_WIDTH +: DATA_WIDTH]);
    if (fifo_wr_en === 1'b1 && wcnt < 64) begin
      wid[wcnt]  = int'(fifo_wr_id);
      wdat[wcnt] = fifo_wr_data;
      wcyc[wcnt] = cyc;
      $display("WRITE cyc=%0d id=%0d data=0x%02h", cyc, fifo_wr_id, fifo_wr_data);
      wcnt++;
    end
  endtask

  always @(negedge clk) check_cycle();

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (head[i] < tail[i]) begin
        req_valid[i] = 1'b1;
        req_data[i*DATA_WIDTH +: DATA_WIDTH] = pd[i][head[i]];
        req_last[i] = pl[i][head[i]];
      end else begin
        req_valid[i] = 1'b0;
        req_data[i*DATA_WIDTH +: DATA_WIDTH] = '0;
        req_last[i] = 1'b0;
      end
    end
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    pd[r][tail[r]] = d;
    pl[r][tail[r]] = l;
    tail[r]++;
  endtask

  task automatic flush();
    for (int i = 0; i < NUM_REQ; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
  endtask

  function automatic logic queues_empty();
    logic e;
    e = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) if (head[i] < tail[i]) e = 1'b0;
    return e;
  endfunction

  // One clock: sample the handshake mid-cycle, advance producers after the edge.
  task automatic step();
    logic [NUM_REQ-1:0] hs;
    @(negedge clk);
    hs = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) if (hs[i]) head[i]++;
    drive();
  endtask

  task automatic wait_writes(input int target, input int budget, input string name);
    int n = 0;
    while (wcnt < target && n < budget) begin
      step();
      n++;
    end
    chk({name, "_writes_done"}, wcnt >= target, 1);
  endtask

  task automatic wait_quiet(input int budget);
    int n = 0;
    while ((busy !== 1'b0 || !queues_empty()) && n < budget) begin
      step();
      n++;
    end
    chk("quiet_reached", (busy === 1'b0) && queues_empty(), 1);
  endtask

  int exp1_id [5];
  int exp1_dat [5];
  int exp2_gap [9];
  int exp4_id [2];

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, writes seen %0d", wcnt);
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int fc;
`ifdef FIFO_WR_ARB_PRIO_EN
    exp1_id  = '{0, 0, 1, 2, 3};
    exp1_dat = '{8'hA0, 8'hA4, 8'hA1, 8'hA2, 8'hA3};
    exp4_id  = '{0, 3};
`else
    exp1_id  = '{0, 1, 2, 3, 0};
    exp1_dat = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
    exp4_id  = '{3, 0};
`endif
    exp2_gap = '{1, 1, 1, 2, 1, 1, 1, 2, 1};

    fifo_full = 1'b0;
    flush();
    drive();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_wr_id", fifo_wr_id, 0);
    rst_n = 1'b1;

    // All four valid with single-beat packets.
    b = wcnt;
    push(0, 8'hA0, 1'b1); push(0, 8'hA4, 1'b1);
    push(1, 8'hA1, 1'b1); push(2, 8'hA2, 1'b1); push(3, 8'hA3, 1'b1);
    drive();
    wait_writes(b + 5, 60, "t1");
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t1_id%0d", k), wid[b+k], exp1_id[k]);
      chk($sformatf("t1_data%0d", k), wdat[b+k], exp1_dat[k]);
      if (k > 0) chk($sformatf("t1_gap%0d", k), wcyc[b+k] - wcyc[b+k-1], 2);
    end
    wait_quiet(20);

    // Requester 2 streams ten beats: bursts of 4, 4, 2.
    b = wcnt;
    for (int k = 0; k < 10; k++) push(2, 8'(8'h20 + k), k == 9);
    drive();
    wait_writes(b + 10, 60, "t2");
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("t2_id%0d", k), wid[b+k], 2);
      chk($sformatf("t2_data%0d", k), wdat[b+k], 8'h20 + k);
      if (k > 0) chk($sformatf("t2_gap%0d", k), wcyc[b+k] - wcyc[b+k-1], exp2_gap[k-1]);
    end
    wait_quiet(20);

    // FIFO full stalls requester 1 after its second beat.
    b = wcnt;
    for (int k = 0; k < 4; k++) push(1, 8'(8'h10 + k), k == 3);
    drive();
    wait_writes(b + 2, 20, "t3_pre");
    fifo_full = 1'b1;
    repeat (5) step();
    chk("t3_no_write_while_full", wcnt, b + 2);
    chk("t3_busy_held", busy, 1);
    chk("t3_grant_held", grant_id, 1);
    fifo_full = 1'b0;
    fc = cyc;
    wait_writes(b + 3, 4, "t3_post");
    chk("t3_beat3_cycle", wcyc[b+2], fc);
    chk("t3_beat3_data", wdat[b+2], 8'h12);
    chk("t3_beat3_id", wid[b+2], 1);
    wait_quiet(20);

    // last_grant = 0 with requesters 0 and 3 both waiting.
    push(0, 8'hE0, 1'b1);
    drive();
    wait_quiet(20);
    b = wcnt;
    push(0, 8'hE1, 1'b1); push(3, 8'hE3, 1'b1);
    drive();
    wait_writes(b + 2, 20, "t4");
    chk("t4_first_id", wid[b], exp4_id[0]);
    chk("t4_second_id", wid[b+1], exp4_id[1]);
    wait_quiet(20);

    // Asynchronous reset in the middle of requester 1's burst.
    push(0, 8'hB0, 1'b1);
    drive();
    wait_quiet(20);
    b = wcnt;
    for (int k = 0; k < 4; k++) push(1, 8'(8'hC0 + k), k == 3);
    drive();
    wait_writes(b + 2, 20, "t5_pre");
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_busy_async", busy, 0);
    chk("t5_wr_en_async", fifo_wr_en, 0);
    chk("t5_ready_async", req_ready, 0);
    chk("t5_wr_id_async", fifo_wr_id, 0);
    chk("t5_grant_async", grant_id, 0);
    flush();
    drive();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    b = wcnt;
    push(0, 8'hD0, 1'b1); push(2, 8'hD2, 1'b1);
    drive();
    wait_writes(b + 2, 20, "t5_post");
    chk("t5_first_id", wid[b], 0);
    chk("t5_second_id", wid[b+1], 2);
    wait_quiet(20);

    // Requester 1 goes idle mid-packet; requester 2 is waiting.
    b = wcnt;
    push(1, 8'h51, 1'b0); push(1, 8'h52, 1'b0); push(2, 8'h60, 1'b1);
    drive();
    wait_writes(b + 3, 30, "t6");
    chk("t6_id0", wid[b], 1);
    chk("t6_id1", wid[b+1], 1);
    chk("t6_id2", wid[b+2], 2);
    chk("t6_data2", wdat[b+2], 8'h60);
    chk("t6_gap", wcyc[b+2] - wcyc[b+1], 3);
    wait_quiet(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_wr_arb.md
Name: sync_fifo_wr_arb

Overview:
- Shares the write port of one sync_fifo between NUM_REQ producers.
- Grants are round-robin, in bursts of up to MAX_BURST beats, bounded by each requester's packet-end marker.
- Drives the FIFO write enable and data. Watches the FIFO full flag for back-pressure.
- Tags each written word with the source ID so downstream can demultiplex.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 8, payload width; matches the FIFO DATA_WIDTH minus ID_W when the tag is stored.
- MAX_BURST, 4, maximum beats per grant (1..255).
- ID_W, derived as $clog2(NUM_REQ), width of the source ID (localparam, not overridable).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester data valid.
- req_data  in  NUM_REQ*DATA_WIDTH  packed payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  in  NUM_REQ  marks the final beat of a packet.
- req_ready  out  NUM_REQ  per-requester accept.
- fifo_full  in  1  FIFO full flag.
- fifo_wr_en  out  1  FIFO write enable.
- fifo_wr_data  out  DATA_WIDTH  payload to the FIFO.
- fifo_wr_id  out  ID_W  source ID of the current write.
- grant_id  out  ID_W  currently granted requester (registered).
- busy  out  1  high while in BURST.

Behaviour:
- Clock and reset: one clock (clk); reset (rst_n) is asynchronous, active-low.
- Reset values:
  - state = IDLE, busy = 0, grant_id = 0.
  - Burst counter = 0.
  - last_grant = NUM_REQ-1, so requester 0 wins the first arbitration.
  - req_ready, fifo_wr_en and fifo_wr_id are all 0; they are combinational from state, which is IDLE.
- State machine: IDLE, BURST.
- IDLE:
  - req_ready = 0, fifo_wr_en = 0.
  - If any req_valid bit is set, pick the first valid requester, searching upward from last_grant+1 modulo NUM_REQ.
  - Register the winner into grant_id, clear the burst counter, and go to BURST next cycle.
  - This costs one arbitration bubble cycle per grant.
- BURST, with g = grant_id:
  - req_ready[g] = ~fifo_full; all other req_ready bits = 0.
  - fifo_wr_en = req_valid[g] & ~fifo_full.
  - fifo_wr_data = req_data[g]; fifo_wr_id = g.
  - This is a zero-latency combinational pass-through.
- Beat: a cycle with req_valid[g] & req_ready[g]. Each beat increments the burst counter.
- BURST to IDLE on the first of:
  - (a) a beat with req_last[g] = 1;
  - (b) a beat that brings the counter to MAX_BURST;
  - (c) req_valid[g] = 0 while fifo_full = 0 (the requester has gone idle).
- On leaving BURST: last_grant <= g, busy falls the next cycle.
- FIFO full:
  - No beat occurs and the counter holds.
  - Condition (c) is not evaluated, so a stalled requester keeps its grant.
  - No write is ever issued while fifo_full = 1.
- MAX_BURST = 1: every beat releases the grant. Round-robin then alternates requesters beat by beat (with a bubble between beats).
- Exit after a packet ends:
  - A new packet from the same requester within the same burst is not possible, because req_last forces exit.
  - After exit, the same requester can win again only if no other requester is valid.
- Requester protocol:
  - Once valid, req_valid, req_data and req_last must stay stable until ready.
  - The arbiter does not check this.
- Reset asserted mid-burst: immediately IDLE, all outputs 0, the partial packet is abandoned, the FIFO contents are unaffected.

Optional Feature:
- Macro: FIFO_WR_ARB_PRIO_EN.
- Defined: requester 0 is high priority. In IDLE, if req_valid[0] = 1 it wins regardless of last_grant. It never pre-empts an active BURST. last_grant is not updated when requester 0's burst ends, so the rotation among 1..NUM_REQ-1 is preserved.
- Undefined: pure round-robin as above.

Decomposition:
- Package sync_fifo_arb_pkg:
  - state enum typedef (IDLE, BURST);
  - a function computing ID_W;
  - burst counter width constant, $clog2(MAX_BURST+1).
- Sub-module rr_pick: combinational rotating-priority picker. Inputs: request vector and last pointer. Outputs: one-hot grant, encoded index and an any-request flag.

Test Plan:
- Reset then req_valid = 4'b1111, all req_last = 1, fifo_full = 0 -> grants in order 0, 1, 2, 3, 0. One write per grant, each preceded by a bubble. fifo_wr_id matches each grant.
- Req 2 streams 10 beats with last on beat 10, MAX_BURST = 4, others idle -> bursts of 4, 4, 2 beats, with one bubble between bursts. Data order is preserved.
- Req 1 in BURST at beat 2; fifo_full = 1 for 5 cycles -> fifo_wr_en = 0 and req_ready[1] = 0 throughout. Grant is retained; beat 3 is written in the cycle full drops.
- Req 0 and req 3 valid, last_grant = 0 -> req 3 is granted first. With FIFO_WR_ARB_PRIO_EN defined, req 0 is granted instead.
- rst_n pulsed low mid-burst (beat 2 of 4) -> busy, fifo_wr_en and req_ready go to 0 asynchronously. First grant after release goes to requester 0.
- Req 1 drops req_valid mid-burst with fifo_full = 0 -> returns to IDLE next cycle, and a waiting req 2 is granted after one bubble.
